// File: rtl/axis_read_interface_pkg.sv
// Shared constants for the AXIS BRAM reader.
// State encoding and prefetch FIFO sizing.
package axis_read_interface_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/axis_read_interface_if.sv
// AXI-Stream beat bundle with master/slave views.
// Field names follow the stream signal names.
interface axis_read_interface_if #(
  parameter int data_width = 512,
  parameter int keep_width = data_width / 8
);

  logic                  t_valid;
  logic                  t_ready;
  logic [data_width-1:0] t_data;
  logic [keep_width-1:0] t_keep;
  logic                  t_last;

  modport master (
    output t_valid, t_data, t_keep, t_last,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_last,
    output t_ready
  );

endinterface

// File: rtl/axis_rd_fifo.sv
// 4-entry prefetch FIFO between BRAM and the stream port.
// Accepts push and pop in the same cycle, even when full.
module axis_rd_fifo
  import axis_read_interface_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [width-1:0]   din,
  input  logic               pop,
  output logic [width-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  localparam int PW = FIFO_CW - 1;

  logic [width-1:0]   mem_q [FIFO_DEPTH];
  logic [width-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [FIFO_CW-1:0] cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FIFO_CW'(FIFO_DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_read_interface.sv
// Streams a BRAM region out as one AXIS packet via a prefetch FIFO.
// AXIS_RD_PARTIAL_KEEP_EN adds last_keep for the final beat's t_keep.
module axis_read_interface
  import axis_read_interface_pkg::*;
#(
  parameter int data_width     = 512,
  parameter int counter_width  = 10,
  parameter int mem_size_depth = 1024,
  parameter int keep_width     = data_width / 8
) (
  input  logic                     axis_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [counter_width-1:0] start_addr,
  input  logic [counter_width:0]   pkt_len,
`ifdef AXIS_RD_PARTIAL_KEEP_EN
  input  logic [keep_width-1:0]    last_keep,
`endif
  input  logic [data_width-1:0]    bram_dout,
  output logic                     bram_ena,
  output logic [counter_width-1:0] bram_address,
  axis_read_interface_if.master    axis,
  output logic                     busy,
  output logic                     done
);

  localparam int FW = data_width + keep_width + 1;
  localparam logic [counter_width:0] DEPTH =
    (counter_width+1)'(mem_size_depth);
  localparam logic [counter_width:0] ONE =
    (counter_width+1)'(1);

  state_t                   state_q, state_d;
  logic [counter_width-1:0] addr_q, addr_d;
  logic [counter_width:0]   len_q, len_d;
  logic [counter_width:0]   issue_q, issue_d;
  logic                     pend_q, pend_d;
  logic                     plast_q, plast_d;

  logic [FW-1:0]      fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [FIFO_CW-1:0] fifo_cnt;
  logic [FIFO_CW:0]   level;
  logic               room, pop, head_last;
  logic [keep_width-1:0] push_keep;

`ifdef AXIS_RD_PARTIAL_KEEP_EN
  logic [keep_width-1:0] keep_q, keep_d;

  always_comb begin
    keep_d = keep_q;
    if (state_q == IDLE && start && pkt_len != '0) begin
      keep_d = last_keep;
    end
  end

  always_ff @(posedge axis_clk or negedge reset) begin
    if (!reset) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign push_keep = plast_q ? keep_q : '1;
`else
  assign push_keep = '1;
`endif

  // Reads issued last cycle land in the FIFO this cycle.
  assign level = {1'b0, fifo_cnt} + {{FIFO_CW{1'b0}}, pend_q};
  assign room  = !fifo_full && (level < (FIFO_CW+1)'(FIFO_DEPTH));

  assign fifo_din  = {plast_q, push_keep, bram_dout};
  assign pop       = !fifo_empty && axis.t_ready;
  assign head_last = fifo_dout[FW-1];

  assign axis.t_valid = !fifo_empty;
  assign axis.t_data  = fifo_empty ? '0 : fifo_dout[data_width-1:0];
  assign axis.t_keep  = fifo_empty ? '0 : fifo_dout[data_width +: keep_width];
  assign axis.t_last  = !fifo_empty && head_last;

  assign bram_address = addr_q + issue_q[counter_width-1:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issue_d  = issue_q;
    pend_d   = 1'b0;
    plast_d  = plast_q;
    bram_ena = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && pkt_len != '0) begin
          addr_d  = start_addr;
          len_d   = (pkt_len > DEPTH) ? DEPTH : pkt_len;
          issue_d = '0;
          state_d = READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (room) begin
          bram_ena = 1'b1;
          pend_d   = 1'b1;
          plast_d  = (issue_q == len_q - ONE);
          issue_d  = issue_q + ONE;
          if (issue_q == len_q - ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && head_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      issue_q <= '0;
      pend_q  <= 1'b0;
      plast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      issue_q <= issue_d;
      pend_q  <= pend_d;
      plast_q <= plast_d;
    end
  end

  axis_rd_fifo #(
    .width (FW)
  ) u_fifo (
    .clk   (axis_clk),
    .rst_n (reset),
    .push  (pend_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_axis_read_interface.sv
// Directed bench for axis_read_interface with a beat/address scoreboard.
// Build with AXIS_RD_PARTIAL_KEEP_EN to exercise last_keep.
module tb_axis_read_interface;

  localparam int DW    = 512;
  localparam int CW    = 10;
  localparam int DEPTH = 1024;
  localparam int KW    = DW / 8;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] start_addr = '0;
  logic [CW:0]   pkt_len = '0;
  logic [KW-1:0] last_keep = '0;
  logic [DW-1:0] bram_dout = '0;
  logic          bram_ena;
  logic [CW-1:0] bram_address;
  logic          busy, done;

  axis_read_interface_if #(.data_width(DW), .keep_width(KW)) axis ();

  axis_read_interface #(
    .data_width     (DW),
    .counter_width  (CW),
    .mem_size_depth (DEPTH),
    .keep_width     (KW)
  ) dut (
    .axis_clk     (clk),
    .reset        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .pkt_len      (pkt_len),
`ifdef AXIS_RD_PARTIAL_KEEP_EN
    .last_keep    (last_keep),
`endif
    .bram_dout    (bram_dout),
    .bram_ena     (bram_ena),
    .bram_address (bram_address),
    .axis         (axis),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (bram_ena) bram_dout <= bram[bram_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t         exp_q [$];
  logic [CW-1:0] addr_q [$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int done_cnt = 0, iss = 0, pops = 0;
  int done_cyc = 0, last_cyc = -10, first_v_cyc = -1, s_cyc = 0;

  task automatic chk(input string tag, input logic [639:0] obs,
                     input logic [639:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, issue gating.
  initial begin : monitor
    beat_t cur, prev_b, e;
    logic  prev_v, prev_stall;
    prev_v = 1'b0;
    prev_stall = 1'b0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cur = {axis.t_last, axis.t_keep, axis.t_data};
        if (prev_stall)
          chk("stall_hold", {axis.t_valid, cur}, {1'b1, prev_b});
        if (bram_ena) begin
          chk("inflight_lt4", 640'(iss - pops < 4), 640'(1));
          chk("addr_expected", 640'(addr_q.size() != 0), 640'(1));
          if (addr_q.size() != 0)
            chk("bram_addr", bram_address, addr_q.pop_front());
          iss++;
        end
        if (axis.t_valid && !prev_v) first_v_cyc = cyc;
        if (axis.t_valid && axis.t_ready) begin
          chk("beat_expected", 640'(exp_q.size() != 0), 640'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", cur, e);
          end
          pops++;
          if (axis.t_last) last_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_last", cyc, last_cyc + 1);
        end
        prev_stall = axis.t_valid && !axis.t_ready;
        prev_b = cur;
        prev_v = axis.t_valid;
      end else begin
        prev_stall = 1'b0;
        prev_v = 1'b0;
      end
    end
  end

  task automatic push_exp(input logic [CW-1:0] a, input int n,
                          input logic [KW-1:0] lk);
    beat_t b;
    logic [CW-1:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = a + CW'(i);
      b.data = bram[ad];
      b.last = (i == n - 1);
`ifdef AXIS_RD_PARTIAL_KEEP_EN
      b.keep = b.last ? lk : '1;
`else
      b.keep = '1;
`endif
      addr_q.push_back(ad);
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [CW-1:0] a, input int len,
                      input int mode, input bit dup,
                      input logic [KW-1:0] lk, input bit lat_chk);
    int base, n_eff, bound;
    base  = done_cnt;
    n_eff = (len > DEPTH) ? DEPTH : len;
    bound = (len == 0) ? 10 : 5000;
    @(posedge clk); #1;
    start_addr = a;
    pkt_len = (CW+1)'(len);
    last_keep = lk;
    start = 1'b1;
    first_v_cyc = -1;
    s_cyc = cyc;
    if (len > 0) push_exp(a, n_eff, lk);
    @(posedge clk); #1;
    start = 1'b0;
    if (dup) begin
      start_addr = a + CW'(100);
      pkt_len = (CW+1)'(2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int n = 0; n < bound && done_cnt == base; n++) begin
      axis.t_ready = (mode == 0) ? 1'b1 : (n % 4 == 0 || n % 4 == 3);
      @(posedge clk); #1;
    end
    axis.t_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("pkt_done", done_cnt - base, (len > 0) ? 1 : 0);
    chk("sb_empty", exp_q.size(), 0);
    chk("addr_empty", addr_q.size(), 0);
    chk("idle_busy", busy, 0);
    if (lat_chk) begin
      chk("first_valid_lat", first_v_cyc - s_cyc, 3);
      chk("done_lat", done_cyc - s_cyc, 3 + n_eff);
    end
  endtask

  initial begin : stim
    int base;
    for (int i = 0; i < DEPTH; i++) bram[i] = DW'(i);
    axis.t_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bram_ena, bram_address, axis.t_valid,
        axis.t_data, axis.t_keep, axis.t_last, busy, done}, 640'(0));
    rst_n = 1'b1;

    send(10'd0, 4, 0, 1'b0, '0, 1'b1);
    send(10'd1022, 4, 0, 1'b0, '0, 1'b1);
    send(10'd200, 8, 1, 1'b0, '0, 1'b0);
    send(10'd300, 1, 0, 1'b1, '0, 1'b0);
    send(10'd400, 0, 0, 1'b0, '0, 1'b0);
    send(10'd7, 3, 0, 1'b0, KW'(64'h0F), 1'b1);

    // Reset in the middle of a 10-beat packet.
    base = done_cnt;
    @(posedge clk); #1;
    start_addr = 10'd50;
    pkt_len = 11'd10;
    start = 1'b1;
    push_exp(10'd50, 10, '0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100 && pops - iss + 10 < 3 + 10 - iss + pops
         && pops < 3 + (pops / 1000) * 0; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {bram_ena, bram_address, axis.t_valid,
        axis.t_data, axis.t_keep, axis.t_last, busy, done}, 640'(0));
    exp_q.delete();
    addr_q.delete();
    iss = 0;
    pops = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, base);
    rst_n = 1'b1;
    send(10'd600, 2, 0, 1'b0, '0, 1'b1);

    send(10'd5, 2000, 0, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_read_interface.md
AXIS_READ_INTERFACE -- requirements
Module: axis_read_interface

Interface
REQ-001 SHALL provide parameter data_width, default 512, AXIS data and BRAM word width in bits.
REQ-002 SHALL provide parameter counter_width, default 10, BRAM address width in bits.
REQ-003 SHALL provide parameter mem_size_depth, default 1024, BRAM depth in words; equals 2**counter_width.
REQ-004 SHALL provide parameter keep_width, default data_width/8, t_keep width.
REQ-005 SHALL provide ports:
 - axis_clk  in  1  sole clock; all logic on rising edge.
 - reset  in  1  asynchronous, active-low reset.
 - start  in  1  one-cycle request to send a packet.
 - start_addr  in  counter_width  BRAM word address of the first beat.
 - pkt_len  in  counter_width+1  packet length in beats.
 - bram_dout  in  data_width  BRAM read data, valid one cycle after bram_ena.
 - bram_ena  out  1  BRAM read enable.
 - bram_address  out  counter_width  BRAM read address.
 - t_valid  out  1  AXIS master valid.
 - t_ready  in  1  AXIS slave ready.
 - t_data  out  data_width  AXIS data.
 - t_keep  out  keep_width  AXIS byte enables.
 - t_last  out  1  last beat of packet.
 - busy  out  1  packet in progress.
 - done  out  1  one-cycle pulse after the last beat handshake.

Function
REQ-006 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-007 IDLE: start=1 with pkt_len>=1 SHALL latch start_addr and pkt_len, set busy=1, and go to READ; start with pkt_len=0 SHALL be ignored.
REQ-008 pkt_len > mem_size_depth SHALL be clamped to mem_size_depth.
REQ-009 start while busy=1 SHALL be ignored.
REQ-010 READ: bram_ena SHALL be 1 in a cycle only when (FIFO occupancy + reads in flight) < 4; bram_address SHALL be start_addr + issued-beat index, modulo mem_size_depth (wraps 1023 -> 0).
REQ-011 Each bram_dout word SHALL be written to a 4-entry FIFO the cycle after its bram_ena.
REQ-012 When all pkt_len reads are issued, the block SHALL go to DRAIN with bram_ena=0.
REQ-013 t_valid SHALL equal FIFO not-empty; t_data, t_keep, and t_last SHALL come from the FIFO head and stay stable while t_valid=1 and t_ready=0.
REQ-014 A beat SHALL pop only on t_valid && t_ready; the FIFO SHALL accept a push and a pop in the same cycle.
REQ-015 t_last SHALL be 1 only on beat pkt_len; a 1-beat packet SHALL carry t_last on its only beat.
REQ-016 With continuous t_ready=1, t_valid SHALL first rise 3 cycles after the start cycle; throughput SHALL then be one beat per cycle with no bubbles.
REQ-017 DRAIN: the handshake of the t_last beat SHALL move the block to DONE.
REQ-018 DONE: the block SHALL assert done=1 for exactly one cycle, set busy=0, and return to IDLE; start in DONE SHALL be ignored.
REQ-019 Beat and issue counters SHALL be counter_width+1 bits wide so a 1024-beat packet does not overflow.

Reset
REQ-020 While reset=0, the block SHALL be in IDLE, flush the FIFO, and drive bram_ena, bram_address, t_valid, t_data, t_keep, t_last, busy, and done to 0.
REQ-021 Reset asserted mid-packet SHALL abort the packet immediately, without t_last or done; the first packet after reset SHALL behave as from power-up.

Configuration
REQ-022 With macro AXIS_RD_PARTIAL_KEEP_EN defined, the block SHALL add input last_keep (keep_width), latched at start; t_keep SHALL be last_keep on the t_last beat and all ones on other beats.
REQ-023 Without AXIS_RD_PARTIAL_KEEP_EN, the last_keep port SHALL be absent and t_keep SHALL be all ones on every beat.

Structure
REQ-024 A shared package SHALL hold the state encoding constants (IDLE=0, READ=1, DRAIN=2, DONE=3) and the FIFO depth constant (4).
REQ-025 The FIFO SHALL be a separate sub-module axis_rd_fifo: 4 entries, data_width+keep_width+1 bits wide, with full/empty/count outputs.

Verification
REQ-026 start_addr=0, pkt_len=4, t_ready=1, BRAM[i]=i -> t_data 0,1,2,3 on consecutive cycles, t_valid first high 3 cycles after start, t_last on beat 4 only, done one cycle after beat 4.
REQ-027 start_addr=1022, pkt_len=4 -> bram_address sequence 1022,1023,0,1; t_data matches those words.
REQ-028 pkt_len=8 with t_ready toggling 1,0,0,1 repeating -> all 8 beats in order, no loss or duplication, data stable while stalled, bram_ena never issued with occupancy+in-flight=4.
REQ-029 pkt_len=1 -> single beat with t_last=1; a second start during busy -> ignored, exactly one packet sent.
REQ-030 reset=0 asserted after beat 3 of a 10-beat packet -> all outputs 0 next cycle, no done; a following 2-beat packet completes correctly.
REQ-031 With AXIS_RD_PARTIAL_KEEP_EN defined, last_keep=0x0F, pkt_len=3 -> t_keep all ones on beats 1-2, 0x0F on beat 3; without the macro, t_keep all ones on every beat.
